// File: rtl/hazard_controller.sv
// Execute-stage hazard sequencer: per-operand forwarding selects, load-use
// stall insertion, multi-cycle front-end squash after a taken branch/jump,
// and saturating stall/flush event counters for performance debug.
module hazard_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid_ip,
    input  logic [4:0]       id_rs1_addr_ip,
    input  logic             id_rs1_used_ip,
    input  logic [4:0]       id_rs2_addr_ip,
    input  logic             id_rs2_used_ip,
    input  logic [4:0]       ex_rd_addr_ip,
    input  logic             ex_reg_write_ip,
    input  logic             ex_is_load_ip,
    input  logic [4:0]       mem_rd_addr_ip,
    input  logic             mem_reg_write_ip,
    input  logic             flush_en_ip,
    output logic [1:0]       fa_mux_op,
    output logic [1:0]       fb_mux_op,
    output logic             stall_op,
    output logic             bubble_op,
    output logic             squash_op,
    output logic [CNT_W-1:0] stall_count_op,
    output logic [CNT_W-1:0] flush_count_op
);

    // forward_mux_code values seen by the EX operand muxes
    localparam logic [1:0] NO_FORWARD_SELECT = 2'd0;
    localparam logic [1:0] EX_RESULT_SELECT  = 2'd1;
    localparam logic [1:0] MEM_RESULT_SELECT = 2'd2;

    // Counter holds the number of squash cycles still owed after the current one.
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [CNT_W-1:0] stall_count_reg, flush_count_reg;

    logic stall_comb, bubble_comb, squash_comb;
    logic stall_evt, flush_evt;

    // Operand 0 is rs1 (A side), operand 1 is rs2 (B side).
    logic [1:0][4:0] src_addr;
    logic [1:0]      src_used;
    logic [1:0]      ex_match;
    logic [1:0]      mem_match;
    logic [1:0][1:0] fwd_sel;
    logic [1:0][1:0] fwd_reg;
    logic            hazard;

    assign src_addr[0] = id_rs1_addr_ip;
    assign src_addr[1] = id_rs2_addr_ip;
    assign src_used[0] = id_rs1_used_ip;
    assign src_used[1] = id_rs2_used_ip;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            // Producer matches require a real write to a non-zero register.
            assign ex_match[gi]  = src_used[gi] & ex_reg_write_ip &
                                   (ex_rd_addr_ip == src_addr[gi]) &
                                   (ex_rd_addr_ip != 5'd0);
            assign mem_match[gi] = src_used[gi] & mem_reg_write_ip &
                                   (mem_rd_addr_ip == src_addr[gi]) &
                                   (mem_rd_addr_ip != 5'd0);

            // The EX producer is younger, so its value wins over MEM.
            assign fwd_sel[gi] = ex_match[gi]  ? EX_RESULT_SELECT  :
                                 mem_match[gi] ? MEM_RESULT_SELECT :
                                                 NO_FORWARD_SELECT;

            // Register the select into the EX cycle; a bubbled or squashed
            // instruction never forwards.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    fwd_reg[gi] <= NO_FORWARD_SELECT;
                end else if (bubble_comb) begin
                    fwd_reg[gi] <= NO_FORWARD_SELECT;
                end else begin
                    fwd_reg[gi] <= fwd_sel[gi];
                end
            end
        end
    endgenerate

    // A load in EX feeding either source of a valid ID instruction must wait.
    assign hazard = id_valid_ip & ex_is_load_ip & (|ex_match);

    // Next-state and control outputs; flush always beats load-use.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        stall_comb  = 1'b0;
        bubble_comb = 1'b0;
        squash_comb = 1'b0;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;
        case (state_reg)
            // LU_STALL lasts one cycle: EX now holds the bubble, so it
            // re-evaluates exactly like RUN.
            ST_RUN, ST_LU_STALL: begin
                if (flush_en_ip) begin
                    squash_comb = 1'b1;
                    bubble_comb = 1'b1;
                    flush_evt   = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_next = ST_FLUSH;
                        cnt_next   = CNT_RELOAD;
                    end else begin
                        state_next = ST_RUN;
                    end
                end else if (hazard) begin
                    stall_comb  = 1'b1;
                    bubble_comb = 1'b1;
                    stall_evt   = 1'b1;
                    state_next  = ST_LU_STALL;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_FLUSH: begin
                squash_comb = 1'b1;
                bubble_comb = 1'b1;
                if (flush_en_ip) begin
                    // A fresh redirect restarts the squash window.
                    flush_evt  = 1'b1;
                    cnt_next   = CNT_RELOAD;
                    state_next = ST_FLUSH;
                end else if (cnt_reg <= CNT_ONE) begin
                    cnt_next   = '0;
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: begin
                state_next = ST_RUN;
                cnt_next   = '0;
            end
        endcase
    end

    // State and squash-window counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Saturating performance counters, bumped on the edge the event is taken.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            if (stall_evt && (stall_count_reg != {CNT_W{1'b1}})) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end
            if (flush_evt && (flush_count_reg != {CNT_W{1'b1}})) begin
                flush_count_reg <= flush_count_reg + 1'b1;
            end
        end
    end

    // Controls are forced low while reset is held so the pipeline is quiet.
    assign stall_op       = reset & stall_comb;
    assign bubble_op      = reset & bubble_comb;
    assign squash_op      = reset & squash_comb;
    assign fa_mux_op      = fwd_reg[0];
    assign fb_mux_op      = fwd_reg[1];
    assign stall_count_op = stall_count_reg;
    assign flush_count_op = flush_count_reg;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_hazard_controller;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 32;

    localparam logic [1:0] NO_FWD  = 2'd0;
    localparam logic [1:0] EX_FWD  = 2'd1;
    localparam logic [1:0] MEM_FWD = 2'd2;

    logic             clock;
    logic             reset;
    logic             id_valid;
    logic [4:0]       rs1, rs2;
    logic             rs1_used, rs2_used;
    logic [4:0]       ex_rd;
    logic             ex_wr, ex_load;
    logic [4:0]       mem_rd;
    logic             mem_wr;
    logic             flush_en;
    logic [1:0]       fa, fb;
    logic             stall, bubble, squash;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          m_flush_left;
    logic [31:0] m_stall_cnt, m_flush_cnt;
    logic [1:0]  m_fa, m_fb;

    hazard_controller #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .id_valid_ip      (id_valid),
        .id_rs1_addr_ip   (rs1),
        .id_rs1_used_ip   (rs1_used),
        .id_rs2_addr_ip   (rs2),
        .id_rs2_used_ip   (rs2_used),
        .ex_rd_addr_ip    (ex_rd),
        .ex_reg_write_ip  (ex_wr),
        .ex_is_load_ip    (ex_load),
        .mem_rd_addr_ip   (mem_rd),
        .mem_reg_write_ip (mem_wr),
        .flush_en_ip      (flush_en),
        .fa_mux_op        (fa),
        .fb_mux_op        (fb),
        .stall_op         (stall),
        .bubble_op        (bubble),
        .squash_op        (squash),
        .stall_count_op   (stall_cnt),
        .flush_count_op   (flush_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Which producer the spec says should feed a source register.
    function automatic logic [1:0] ref_fwd(input logic [4:0] a, input logic used);
        if (used && a != 0 && ex_wr && ex_rd == a) return EX_FWD;
        if (used && a != 0 && mem_wr && mem_rd == a) return MEM_FWD;
        return NO_FWD;
    endfunction

    function automatic logic ref_hazard();
        return id_valid && ex_load &&
               (ref_fwd(rs1, rs1_used) == EX_FWD || ref_fwd(rs2, rs2_used) == EX_FWD);
    endfunction

    function automatic logic ref_squash();
        return reset && (flush_en || m_flush_left > 0);
    endfunction

    function automatic logic ref_stall();
        return reset && !ref_squash() && ref_hazard();
    endfunction

    task automatic model_reset();
        m_flush_left = 0;
        m_stall_cnt  = 0;
        m_flush_cnt  = 0;
        m_fa         = NO_FWD;
        m_fb         = NO_FWD;
    endtask

    task automatic clear_inputs();
        id_valid = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
        ex_rd = 0; ex_wr = 0; ex_load = 0; mem_rd = 0; mem_wr = 0; flush_en = 0;
    endtask

    // Advance one clock, updating the model from the inputs held this cycle.
    task automatic tick();
        logic sq, st;
        sq = ref_squash();
        st = ref_stall();
        if (reset) begin
            m_fa = (sq || st) ? NO_FWD : ref_fwd(rs1, rs1_used);
            m_fb = (sq || st) ? NO_FWD : ref_fwd(rs2, rs2_used);
            if (st && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
            if (flush_en && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt = m_flush_cnt + 1;
            if (flush_en) m_flush_left = FLUSH_CYCLES - 1;
            else if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        // Hazard and flush both requested while in reset: controls must stay low.
        id_valid = 1; rs1 = 5'd4; rs1_used = 1; ex_rd = 5'd4; ex_wr = 1; ex_load = 1;
        flush_en = 1;
        reset = 1;
        #1 reset = 0;
        model_reset();
        #2;
        checks++; if (stall !== 1'b0)  begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall); end
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %0d expected 0", bubble); end
        checks++; if (squash !== 1'b0) begin errors++; $display("FAIL reset_squash: got %0d expected 0", squash); end
        checks++; if (fa !== NO_FWD || fb !== NO_FWD) begin errors++; $display("FAIL reset_fwd: got fa=%0d fb=%0d expected 0/0", fa, fb); end
        checks++; if (stall_cnt !== 0 || flush_cnt !== 0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        @(posedge clock);
        #1;
        clear_inputs();
        reset = 1;
        $display("test_reset done");
    endtask

    task automatic test_ex_forward();
        clear_inputs();
        ex_rd = 5'd5; ex_wr = 1;
        id_valid = 1; rs1 = 5'd5; rs1_used = 1; rs2 = 5'd6; rs2_used = 1;
        #2;
        checks++; if (stall !== 1'b0 || bubble !== 1'b0) begin errors++; $display("FAIL exfwd_nostall: got stall=%0d bubble=%0d expected 0/0", stall, bubble); end
        tick();
        checks++; if (fa !== EX_FWD) begin errors++; $display("FAIL exfwd_fa: got %0d expected %0d", fa, EX_FWD); end
        checks++; if (fb !== NO_FWD) begin errors++; $display("FAIL exfwd_fb: got %0d expected %0d", fb, NO_FWD); end
        $display("test_ex_forward done");
    endtask

    task automatic test_load_use();
        clear_inputs();
        ex_rd = 5'd7; ex_wr = 1; ex_load = 1;
        id_valid = 1; rs1 = 5'd1; rs1_used = 1; rs2 = 5'd7; rs2_used = 1;
        #2;
        checks++; if (stall !== 1'b1 || bubble !== 1'b1 || squash !== 1'b0) begin errors++; $display("FAIL lu_stall: got stall=%0d bubble=%0d squash=%0d expected 1/1/0", stall, bubble, squash); end
        tick();
        checks++; if (stall_cnt !== 1) begin errors++; $display("FAIL lu_count: got %0d expected 1", stall_cnt); end
        checks++; if (fa !== NO_FWD || fb !== NO_FWD) begin errors++; $display("FAIL lu_bubble_fwd: got fa=%0d fb=%0d expected 0/0", fa, fb); end
        // The load advances to MEM, a bubble sits in EX, ID is re-evaluated.
        ex_rd = 5'd0; ex_wr = 0; ex_load = 0;
        mem_rd = 5'd7; mem_wr = 1;
        #2;
        checks++; if (stall !== 1'b0 || bubble !== 1'b0) begin errors++; $display("FAIL lu_one_cycle: got stall=%0d bubble=%0d expected 0/0", stall, bubble); end
        tick();
        checks++; if (fb !== MEM_FWD) begin errors++; $display("FAIL lu_fb_mem: got %0d expected %0d", fb, MEM_FWD); end
        checks++; if (stall_cnt !== 1) begin errors++; $display("FAIL lu_count_hold: got %0d expected 1", stall_cnt); end
        $display("test_load_use done");
    endtask

    task automatic test_priority_and_x0();
        clear_inputs();
        ex_rd = 5'd3; ex_wr = 1; mem_rd = 5'd3; mem_wr = 1;
        id_valid = 1; rs1 = 5'd3; rs1_used = 1; rs2 = 5'd3; rs2_used = 1;
        tick();
        checks++; if (fa !== EX_FWD || fb !== EX_FWD) begin errors++; $display("FAIL youngest_wins: got fa=%0d fb=%0d expected 1/1", fa, fb); end
        ex_rd = 5'd0; mem_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        tick();
        checks++; if (fa !== NO_FWD || fb !== NO_FWD) begin errors++; $display("FAIL x0_no_fwd: got fa=%0d fb=%0d expected 0/0", fa, fb); end
        ex_rd = 5'd9; mem_rd = 5'd10; rs1 = 5'd9; rs2 = 5'd10; rs1_used = 0; rs2_used = 1;
        tick();
        checks++; if (fa !== NO_FWD || fb !== MEM_FWD) begin errors++; $display("FAIL unused_src: got fa=%0d fb=%0d expected 0/2", fa, fb); end
        $display("test_priority_and_x0 done");
    endtask

    task automatic test_flush();
        int sq_cycles;
        logic [31:0] base;
        clear_inputs();
        base = m_flush_cnt;
        sq_cycles = 0;
        flush_en = 1;
        #2;
        checks++; if (squash !== 1'b1 || bubble !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL flush_first: got squash=%0d bubble=%0d stall=%0d expected 1/1/0", squash, bubble, stall); end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) #2;
            if (squash) sq_cycles++;
            tick();
            flush_en = 0;
        end
        checks++; if (sq_cycles != FLUSH_CYCLES) begin errors++; $display("FAIL flush_len: got %0d expected %0d", sq_cycles, FLUSH_CYCLES); end
        checks++; if (flush_cnt !== base + 1) begin errors++; $display("FAIL flush_count: got %0d expected %0d", flush_cnt, base + 1); end
        $display("test_flush done");
    endtask

    task automatic test_stall_flush_same_cycle();
        logic [31:0] st_base, fl_base;
        clear_inputs();
        st_base = m_stall_cnt;
        fl_base = m_flush_cnt;
        ex_rd = 5'd8; ex_wr = 1; ex_load = 1;
        id_valid = 1; rs1 = 5'd8; rs1_used = 1;
        flush_en = 1;
        #2;
        checks++; if (squash !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL prio_squash_only: got squash=%0d stall=%0d expected 1/0", squash, stall); end
        tick();
        flush_en = 0;
        #2;
        checks++; if (squash !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL prio_flush_ignores_lu: got squash=%0d stall=%0d expected 1/0", squash, stall); end
        tick();
        clear_inputs();
        #2;
        checks++; if (stall_cnt !== st_base) begin errors++; $display("FAIL prio_stall_count: got %0d expected %0d", stall_cnt, st_base); end
        checks++; if (flush_cnt !== fl_base + 1) begin errors++; $display("FAIL prio_flush_count: got %0d expected %0d", flush_cnt, fl_base + 1); end
        tick();
        $display("test_stall_flush_same_cycle done");
    endtask

    task automatic test_reset_mid_flush();
        clear_inputs();
        flush_en = 1;
        tick();
        flush_en = 0;
        #1;
        reset = 0;
        model_reset();
        #1;
        checks++; if (squash !== 1'b0 || bubble !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got squash=%0d bubble=%0d stall=%0d expected 0/0/0", squash, bubble, stall); end
        checks++; if (fa !== NO_FWD || fb !== NO_FWD || stall_cnt !== 0 || flush_cnt !== 0) begin errors++; $display("FAIL rstmid_state: got fa=%0d fb=%0d sc=%0d fc=%0d expected all 0", fa, fb, stall_cnt, flush_cnt); end
        #2;
        reset = 1;
        ex_rd = 5'd12; ex_wr = 1; id_valid = 1; rs2 = 5'd12; rs2_used = 1;
        #1;
        checks++; if (squash !== 1'b0) begin errors++; $display("FAIL rstmid_run_squash: got %0d expected 0", squash); end
        tick();
        checks++; if (fb !== EX_FWD || squash !== 1'b0) begin errors++; $display("FAIL rstmid_run_fwd: got fb=%0d squash=%0d expected 1/0", fb, squash); end
        $display("test_reset_mid_flush done");
    endtask

    task automatic test_random();
        logic prev_stall;
        logic exp_sq, exp_st;
        int bad;
        prev_stall = 0;
        for (int i = 0; i < 400; i++) begin
            id_valid = ($urandom_range(0, 7) != 0);
            rs1 = 5'($urandom_range(0, 5));
            rs2 = 5'($urandom_range(0, 5));
            rs1_used = $urandom_range(0, 3) != 0;
            rs2_used = $urandom_range(0, 3) != 0;
            mem_rd = 5'($urandom_range(0, 5));
            mem_wr = $urandom_range(0, 1) != 0;
            flush_en = ($urandom_range(0, 7) == 0);
            if (prev_stall) begin
                // EX holds the bubble inserted by the previous stall.
                ex_rd = 5'($urandom_range(0, 5)); ex_wr = 0; ex_load = 0;
            end else begin
                ex_rd = 5'($urandom_range(0, 5));
                ex_wr = $urandom_range(0, 3) != 0;
                ex_load = $urandom_range(0, 2) == 0;
            end
            #2;
            exp_sq = ref_squash();
            exp_st = ref_stall();
            bad = 0;
            checks++;
            if (squash !== exp_sq || stall !== exp_st || bubble !== (exp_sq | exp_st)) bad = 1;
            if (fa !== m_fa || fb !== m_fb) bad = 1;
            if (stall_cnt !== m_stall_cnt || flush_cnt !== m_flush_cnt) bad = 1;
            if (bad) begin
                errors++;
                $display("FAIL random_cycle%0d: got st=%0d bu=%0d sq=%0d fa=%0d fb=%0d sc=%0d fc=%0d expected st=%0d bu=%0d sq=%0d fa=%0d fb=%0d sc=%0d fc=%0d",
                         i, stall, bubble, squash, fa, fb, stall_cnt, flush_cnt,
                         exp_st, exp_st | exp_sq, exp_sq, m_fa, m_fb, m_stall_cnt, m_flush_cnt);
            end
            prev_stall = exp_st;
            tick();
        end
        $display("test_random done: stalls=%0d flushes=%0d", m_stall_cnt, m_flush_cnt);
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        model_reset();
        test_reset();
        test_ex_forward();
        test_load_use();
        test_priority_and_x0();
        test_flush();
        test_stall_flush_same_cycle();
        test_reset_mid_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
